// File: rtl/decode_ctrl_stage.sv
// Registered opcode decoder stage: valid/ready pipeline register, branch flush,
// illegal-opcode flagging, mul/div/mod structural stall and a saturating issue counter.
module decode_ctrl_stage #(
  parameter int INST_W         = 32,
  parameter int OPC_MSB        = 31,
  parameter int IMM_BIT        = 26,
  parameter int MULDIV_LAT     = 4,
  parameter int SUPPORT_MULDIV = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [21:0]       out_ctrl,
  output logic [INST_W-1:0] out_inst,
  output logic              out_illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_count
);

  localparam int CSt = 0, CLd = 1, CBeq = 2, CBgt = 3, CRet = 4, CImm = 5, CWb = 6;
  localparam int CUbranch = 7, CCall = 8, CAdd = 9, CSub = 10, CCmp = 11, CMul = 12;
  localparam int CDiv = 13, CMod = 14, CLsl = 15, CLsr = 16, CAsr = 17, COr = 18;
  localparam int CAnd = 19, CNot = 20, CMov = 21;

  localparam int BusyW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic [4:0] {
    OpAdd = 5'b00000, OpSub = 5'b00001, OpMul = 5'b00010, OpDiv = 5'b00011,
    OpMod = 5'b00100, OpCmp = 5'b00101, OpAnd = 5'b00110, OpOr  = 5'b00111,
    OpNot = 5'b01000, OpMov = 5'b01001, OpLsl = 5'b01010, OpLsr = 5'b01011,
    OpAsr = 5'b01100, OpNop = 5'b01101, OpLd  = 5'b01110, OpSt  = 5'b01111,
    OpBeq = 5'b10000, OpBgt = 5'b10001, OpB   = 5'b10010, OpCall = 5'b10011,
    OpRet = 5'b10100
  } opcode_t;

  logic [4:0]        opcode;
  logic [21:0]       decCtrl;
  logic              decIllegal;
  logic              validQ;
  logic [21:0]       ctrlQ;
  logic [INST_W-1:0] instQ;
  logic              illegalQ;
  logic [BusyW-1:0]  busyCnt;
  logic [CNT_W-1:0]  issueCount;
  logic              accept;
  logic              transfer;
  logic              heldIsMulDiv;

  assign opcode = in_inst[OPC_MSB -: 5];

  // Illegal or unsupported opcodes decode to an all-zero control word, immediate flag included.
  always_comb begin
    decCtrl    = '0;
    decIllegal = 1'b0;
    case (opcode)
      OpAdd:  begin decCtrl[CAdd] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpSub:  begin decCtrl[CSub] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpMul:  if (SUPPORT_MULDIV != 0) begin decCtrl[CMul] = 1'b1; decCtrl[CWb] = 1'b1; end
              else decIllegal = 1'b1;
      OpDiv:  if (SUPPORT_MULDIV != 0) begin decCtrl[CDiv] = 1'b1; decCtrl[CWb] = 1'b1; end
              else decIllegal = 1'b1;
      OpMod:  if (SUPPORT_MULDIV != 0) begin decCtrl[CMod] = 1'b1; decCtrl[CWb] = 1'b1; end
              else decIllegal = 1'b1;
      OpCmp:  decCtrl[CCmp] = 1'b1;
      OpAnd:  begin decCtrl[CAnd] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpOr:   begin decCtrl[COr]  = 1'b1; decCtrl[CWb] = 1'b1; end
      OpNot:  begin decCtrl[CNot] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpMov:  begin decCtrl[CMov] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpLsl:  begin decCtrl[CLsl] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpLsr:  begin decCtrl[CLsr] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpAsr:  begin decCtrl[CAsr] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpNop:  decCtrl = '0;
      OpLd:   begin decCtrl[CLd] = 1'b1; decCtrl[CAdd] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpSt:   begin decCtrl[CSt] = 1'b1; decCtrl[CAdd] = 1'b1; end
      OpBeq:  decCtrl[CBeq] = 1'b1;
      OpBgt:  decCtrl[CBgt] = 1'b1;
      OpB:    decCtrl[CUbranch] = 1'b1;
      OpCall: begin decCtrl[CUbranch] = 1'b1; decCtrl[CCall] = 1'b1; decCtrl[CWb] = 1'b1; end
      OpRet:  begin decCtrl[CRet] = 1'b1; decCtrl[CUbranch] = 1'b1; end
      default: decIllegal = 1'b1;
    endcase
    if (!decIllegal) decCtrl[CImm] = in_inst[IMM_BIT];
  end

  assign heldIsMulDiv = ctrlQ[CMul] | ctrlQ[CDiv] | ctrlQ[CMod];
  assign out_valid    = validQ & (busyCnt == '0);
  assign in_ready     = ~flush & (~validQ | (out_valid & out_ready));
  assign accept       = in_valid & in_ready;
  assign transfer     = out_valid & out_ready;

  // Pipeline register: flush wins, accept reloads (even while draining), drain alone empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ   <= 1'b0;
      ctrlQ    <= '0;
      instQ    <= '0;
      illegalQ <= 1'b0;
    end else if (flush) begin
      validQ <= 1'b0;
    end else if (accept) begin
      validQ   <= 1'b1;
      ctrlQ    <= decCtrl;
      instQ    <= in_inst;
      illegalQ <= decIllegal;
    end else if (transfer) begin
      validQ <= 1'b0;
    end
  end

  // Occupancy of the shared mul/div/mod unit starts when such an op leaves the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyCnt <= '0;
    end else if (transfer && heldIsMulDiv) begin
      busyCnt <= BusyW'(MULDIV_LAT - 1);
    end else if (busyCnt != '0) begin
      busyCnt <= busyCnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issueCount <= '0;
    end else if (transfer && (issueCount != {CNT_W{1'b1}})) begin
      issueCount <= issueCount + 1'b1;
    end
  end

  assign out_ctrl    = ctrlQ;
  assign out_inst    = instQ;
  assign out_illegal = illegalQ;
  assign busy        = (busyCnt != '0);
  assign issue_count = issueCount;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: decode table streamed back to back, then
// hand-written stall, hold, flush, reset and reduced-configuration sequences.
module tb_decode_ctrl_stage;

  typedef struct {
    logic [31:0] inst;
    logic [21:0] ctrl;
    logic        illegal;
  } vec_t;

  localparam int NumVec = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal, busy;
  logic [31:0] in_inst, out_inst;
  logic [21:0] out_ctrl;
  logic [15:0] issue_count;

  logic        inValid2, inReady2, flush2, outValid2, outReady2, outIllegal2, busy2;
  logic [31:0] inInst2, outInst2;
  logic [21:0] outCtrl2;
  logic [1:0]  issueCount2;

  int   nChecks = 0;
  int   nFail = 0;
  vec_t vecs[NumVec];

  always #5 clk = ~clk;

  decode_ctrl_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_inst(out_inst), .out_illegal(out_illegal), .busy(busy), .issue_count(issue_count)
  );

  decode_ctrl_stage #(.SUPPORT_MULDIV(0), .CNT_W(2)) dutNoMul (
    .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2), .in_inst(inInst2),
    .flush(flush2), .out_valid(outValid2), .out_ready(outReady2), .out_ctrl(outCtrl2),
    .out_inst(outInst2), .out_illegal(outIllegal2), .busy(busy2), .issue_count(issueCount2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic rdy,
                               input logic fl);
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h04000123, 22'h000260, 1'b0};  // add imm
    vecs[1]  = '{32'h08000000, 22'h000440, 1'b0};  // sub
    vecs[2]  = '{32'h28000000, 22'h000800, 1'b0};  // cmp
    vecs[3]  = '{32'h30000000, 22'h080040, 1'b0};  // and
    vecs[4]  = '{32'h38000000, 22'h040040, 1'b0};  // or
    vecs[5]  = '{32'h44000000, 22'h100060, 1'b0};  // not imm
    vecs[6]  = '{32'h48000000, 22'h200040, 1'b0};  // mov
    vecs[7]  = '{32'h50000000, 22'h008040, 1'b0};  // lsl
    vecs[8]  = '{32'h58000000, 22'h010040, 1'b0};  // lsr
    vecs[9]  = '{32'h60000000, 22'h020040, 1'b0};  // asr
    vecs[10] = '{32'h68000000, 22'h000000, 1'b0};  // nop
    vecs[11] = '{32'h6C000000, 22'h000020, 1'b0};  // nop imm
    vecs[12] = '{32'h70000000, 22'h000242, 1'b0};  // ld
    vecs[13] = '{32'h78000000, 22'h000201, 1'b0};  // st
    vecs[14] = '{32'h80000000, 22'h000004, 1'b0};  // beq
    vecs[15] = '{32'h88000000, 22'h000008, 1'b0};  // bgt
    vecs[16] = '{32'h90000000, 22'h000080, 1'b0};  // b
    vecs[17] = '{32'h98000000, 22'h0001C0, 1'b0};  // call
    vecs[18] = '{32'hA0000000, 22'h000090, 1'b0};  // ret
    vecs[19] = '{32'hA4000000, 22'h0000B0, 1'b0};  // ret imm
    vecs[20] = '{32'hA8000000, 22'h000000, 1'b1};  // opcode 10101
    vecs[21] = '{32'hFC00BEEF, 22'h000000, 1'b1};  // opcode 11111 with imm bit

    rst = 1'b1;
    inValid2 = 1'b0; inInst2 = '0; outReady2 = 1'b0; flush2 = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_ctrl", out_ctrl, 0);
    checkOutput("reset out_inst", out_inst, 0);
    checkOutput("reset out_illegal", out_illegal, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset issue_count", issue_count, 0);
    checkOutput("reset in_ready", in_ready, 1);

    // Back-to-back stream: one capture and one transfer per cycle.
    for (int i = 0; i < NumVec; i++) begin
      applyStimulus(1'b1, vecs[i].inst, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick();
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d out_ctrl", i), out_ctrl, vecs[i].ctrl);
      checkOutput($sformatf("vec%0d out_inst", i), out_inst, vecs[i].inst);
      checkOutput($sformatf("vec%0d out_illegal", i), out_illegal, vecs[i].illegal);
      checkOutput($sformatf("vec%0d issue_count", i), issue_count, i);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain out_valid", out_valid, 0);
    checkOutput("drain issue_count", issue_count, NumVec);

    // mul followed by add: add held invisible for three busy cycles.
    applyStimulus(1'b1, 32'h10000000, 1'b1, 1'b0);
    tick();
    checkOutput("mul out_valid", out_valid, 1);
    checkOutput("mul out_ctrl", out_ctrl, 22'h001040);
    checkOutput("mul busy before issue", busy, 0);
    applyStimulus(1'b1, 32'h04000000, 1'b1, 1'b0);
    checkOutput("mul drain in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall in_ready", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("stall%0d busy", k), busy, (k < 3) ? 1 : 0);
      checkOutput($sformatf("stall%0d out_valid", k), out_valid, (k < 3) ? 0 : 1);
      if (k < 3) tick();
    end
    checkOutput("after stall out_ctrl", out_ctrl, 22'h000260);
    tick();
    checkOutput("after stall drain out_valid", out_valid, 0);
    checkOutput("after stall issue_count", issue_count, NumVec + 2);

    // Hold under backpressure, then flush with a competing input.
    applyStimulus(1'b1, 32'h04000000, 1'b0, 1'b0);
    tick();
    checkOutput("hold out_valid", out_valid, 1);
    applyStimulus(1'b1, 32'h08000000, 1'b0, 1'b0);
    checkOutput("hold in_ready", in_ready, 0);
    tick();
    checkOutput("hold out_ctrl", out_ctrl, 22'h000260);
    checkOutput("hold out_inst", out_inst, 32'h04000000);
    checkOutput("hold out_valid still", out_valid, 1);
    applyStimulus(1'b1, 32'h08000000, 1'b0, 1'b1);
    checkOutput("flush in_ready", in_ready, 0);
    tick();
    checkOutput("flush out_valid", out_valid, 0);
    checkOutput("flush issue_count", issue_count, NumVec + 2);

    // Flush coinciding with a transfer: transfer counts, register empties.
    applyStimulus(1'b1, 32'h38000000, 1'b1, 1'b0);
    tick();
    checkOutput("flush+xfer load", out_ctrl, 22'h040040);
    applyStimulus(1'b1, 32'h08000000, 1'b1, 1'b1);
    tick();
    checkOutput("flush+xfer out_valid", out_valid, 0);
    checkOutput("flush+xfer issue_count", issue_count, NumVec + 3);

    // Reset while busy with an instruction waiting behind the stall.
    applyStimulus(1'b1, 32'h10000000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h04000000, 1'b1, 1'b0);
    tick();
    checkOutput("pre-reset busy", busy, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-stall reset busy", busy, 0);
    checkOutput("mid-stall reset out_valid", out_valid, 0);
    checkOutput("mid-stall reset issue_count", issue_count, 0);
    tick();
    checkOutput("mid-stall reset discards held", out_valid, 0);

    // No mul/div/mod support and a 2-bit counter.
    inValid2 = 1'b1; inInst2 = 32'h10000000; outReady2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        checkOutput("nomul out_valid", outValid2, 1);
        checkOutput("nomul out_ctrl", outCtrl2, 0);
        checkOutput("nomul out_illegal", outIllegal2, 1);
      end
      if (i == 1) checkOutput("nomul busy", busy2, 0);
    end
    inValid2 = 1'b0;
    tick();
    checkOutput("nomul saturated issue_count", issueCount2, 3);
    checkOutput("nomul drain out_valid", outValid2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
